stopwatch_controller: RTL
=========================

# stopwatch_controller

Sequencing controller for the stopwatch timebase. Runs from the single 1 MHz system clock. Derives a one-cycle 10 ms tick enable from an internal prescaler that it starts, pauses and clears. Drives a BCD minutes:seconds.centiseconds counter with start/stop, lap-freeze and clear control from three pre-debounced buttons, and sits between the button conditioning logic and the 7-segment display multiplexer.

## Interface
- DIV, default 10000: `clk_in` cycles per tick (1 MHz / 100 Hz); must be ≥ 2
- CNT_W, default 14: prescaler width; must satisfy 2^CNT_W ≥ DIV
- clk_in  in  1  1 MHz system clock; the only clock
- res  in  1  reset; synchronous, active-high
- btn_start_stop  in  1  debounced level, synchronous to `clk_in`; the rising edge is the event
- btn_lap  in  1  debounced level; the rising edge is the event
- btn_clear  in  1  debounced level; the rising edge is the event
- disp_min_t  out  3  minutes tens digit (0–5)
- disp_min_o  out  4  minutes ones digit (0–9)
- disp_sec_t  out  3  seconds tens digit (0–5)
- disp_sec_o  out  4  seconds ones digit (0–9)
- disp_cs_t  out  4  centiseconds tens digit (0–9)
- disp_cs_o  out  4  centiseconds ones digit (0–9)
- running  out  1  high in RUNNING or LAP
- lap_active  out  1  high in LAP; the display shows the frozen snapshot
- overflow  out  1  sticky; set on wrap past 59:59.99
- tick  out  1  one-cycle prescaler tick, exported for debug and verification

## Operation
- Edge detection: evt_x = btn_x & ~btn_x_q. `btn_x_q` resets to 1, so a button held through reset produces no event.
- Event priority within one cycle: clear > start_stop > lap. Lower-priority events in that cycle are dropped.
- States: IDLE, RUNNING, PAUSED, LAP.
  - IDLE: start_stop → RUNNING and clear the prescaler to 0. lap and clear are ignored.
  - RUNNING: start_stop → PAUSED. lap → LAP and capture the snapshot. clear is ignored.
  - LAP: start_stop → PAUSED, display returns to live. lap → RUNNING. clear is ignored.
  - PAUSED: start_stop → RUNNING; the prescaler resumes from its held value, with no restart. clear → IDLE; zero the counter, prescaler and overflow. lap is ignored.
- Prescaler:
  - Increments only in RUNNING or LAP; holds otherwise.
  - At DIV-1 it asserts `tick` for that cycle and wraps to 0 on the next edge.
- Time counter: advances by 1 cs on each tick.
  - Cascade: cs_o 9→0 carries to cs_t; cs_t 9→0 carries to sec_o; sec_o 9→0 carries to sec_t; sec_t 5→0 carries to min_o; min_o 9→0 carries to min_t; min_t 5→0 wraps.
  - At 59:59.99, a tick produces 00:00.00 and sets `overflow`. Only the IDLE-bound clear clears `overflow`.
- Display output:
  - In LAP, `disp_*` = snapshot registers.
  - In every other state, `disp_*` = live counter.
  - The live counter keeps counting during LAP.
- Digits never take values outside their stated ranges. No binary-to-BCD conversion is needed.

## Timing
- An event detected at edge N sets the new state, `running` and `lap_active` visible after edge N.
- Start from IDLE at edge N: the prescaler is 0 after N, the first tick is asserted in cycle N+DIV, and cs=01 is visible after edge N+DIV.
- Snapshot = live counter value at the lap edge. A tick in the same cycle is not included.
- Tick coinciding with start_stop (RUNNING→PAUSED): the tick is honored and the counter advances; the prescaler then holds at 0.
- Tick coinciding with lap exit: the tick is honored; the display shows the updated live value.
- `res` high at any edge:
  - All outputs 0 and state IDLE after that edge; prescaler, counter, snapshot and overflow 0.
  - `btn_*_q` = 1.
  - Reset takes priority over every event.
- No combinational path from `btn_*` to any output. All outputs are registered, or are a mux of registers selected by the state register.

## Structure
- Shared package `stopwatch_pkg`:
  - state enum (IDLE, RUNNING, PAUSED, LAP)
  - DIV_DEFAULT = 10000
  - digit limits: 9, 5
  - digit width constants
- Sub-module `tick_prescaler`:
  - ports: `clk_in`, `res`, `en`, `clr`, `tick`; parameters DIV, CNT_W
  - `clr` overrides `en`
- The BCD cascade, snapshot registers and FSM live in `stopwatch_controller`.

## Test plan
Run with DIV=4 for speed unless noted.
- Reset with `btn_start_stop` held high, release `res` → no start event, state IDLE, all `disp_*` 0.
- start_stop edge, run 400 cycles → `tick` every 4th cycle, display 00:01.00, `running`=1.
- Preset 59:59.99, run, one tick → display 00:00.00, `overflow`=1. Pause, clear → `overflow`=0, IDLE.
- RUNNING at 00:00.05, lap edge → display frozen at 00:00.05 while the live counter reaches 00:00.09 after 16 cycles. Second lap edge → display 00:00.09, RUNNING.
- Pause 2 cycles after a tick, hold 50 cycles, resume → next tick exactly 2 cycles after resume. clear pressed while RUNNING → ignored.
- start_stop, lap and clear rising in the same cycle while PAUSED → IDLE with zeros. Same stimulus while RUNNING → PAUSED, lap ignored.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timebase: FSM states,
// BCD digit widths/limits and the packed time-of-day record.
package stopwatch_pkg;

  localparam int DIV_DEFAULT = 10000;

  localparam int T_W = 3;
  localparam int O_W = 4;

  localparam logic [O_W-1:0] MAX_9 = 4'd9;
  localparam logic [T_W-1:0] MAX_5 = 3'd5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    LAP     = 2'd3
  } state_t;

  typedef struct packed {
    logic [T_W-1:0] min_t;
    logic [O_W-1:0] min_o;
    logic [T_W-1:0] sec_t;
    logic [O_W-1:0] sec_o;
    logic [O_W-1:0] cs_t;
    logic [O_W-1:0] cs_o;
  } bcd_time_t;

  localparam bcd_time_t TIME_MAX = '{
    min_t: MAX_5, min_o: MAX_9, sec_t: MAX_5,
    sec_o: MAX_9, cs_t: MAX_9, cs_o: MAX_9
  };

endpackage

// File: rtl/stopwatch_controller_if.sv
// Button inputs and display/status outputs between the button conditioning
// logic (master) and the stopwatch controller (slave).
interface stopwatch_controller_if;
  import stopwatch_pkg::*;

  logic           btn_start_stop;
  logic           btn_lap;
  logic           btn_clear;
  logic [T_W-1:0] disp_min_t;
  logic [O_W-1:0] disp_min_o;
  logic [T_W-1:0] disp_sec_t;
  logic [O_W-1:0] disp_sec_o;
  logic [O_W-1:0] disp_cs_t;
  logic [O_W-1:0] disp_cs_o;
  logic           running;
  logic           lap_active;
  logic           overflow;
  logic           tick;

  modport master (
    output btn_start_stop, btn_lap, btn_clear,
    input  disp_min_t, disp_min_o, disp_sec_t, disp_sec_o, disp_cs_t, disp_cs_o,
    input  running, lap_active, overflow, tick
  );

  modport slave (
    input  btn_start_stop, btn_lap, btn_clear,
    output disp_min_t, disp_min_o, disp_sec_t, disp_sec_o, disp_cs_t, disp_cs_o,
    output running, lap_active, overflow, tick
  );

endinterface

// File: rtl/tick_prescaler.sv
// Free-running divide-by-DIV prescaler with hold (en low) and clear;
// tick is high for the single enabled cycle at terminal count.
module tick_prescaler
  import stopwatch_pkg::*;
#(
  parameter int DIV   = DIV_DEFAULT,
  parameter int CNT_W = 14
) (
  input  logic clk_in,
  input  logic res,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk_in) begin
    if (res || clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + CNT_W'(1);
    end
  end

  assign tick = en && (count == LAST);

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch sequencing: button edge detection, IDLE/RUNNING/PAUSED/LAP FSM,
// BCD mm:ss.cc cascade with lap snapshot and sticky overflow.
module stopwatch_controller
  import stopwatch_pkg::*;
#(
  parameter int DIV   = DIV_DEFAULT,
  parameter int CNT_W = 14
) (
  input  logic clk_in,
  input  logic res,
  stopwatch_controller_if.slave bus
);

  state_t    state, state_nxt;
  bcd_time_t cnt, cnt_nxt;
  bcd_time_t snap, snap_nxt;
  bcd_time_t disp;
  logic      ovf, ovf_nxt;
  logic      ss_q, lap_q, clr_q;
  logic      evt_ss, evt_lap, evt_clr;
  logic      presc_en, presc_clr, tick;

  function automatic bcd_time_t bcd_inc(input bcd_time_t t);
    bcd_time_t r;
    logic      carry;
    r     = t;
    carry = 1'b1;
    if (t.cs_o == MAX_9) r.cs_o = '0;
    else begin r.cs_o = t.cs_o + 4'd1; carry = 1'b0; end
    if (carry) begin
      if (t.cs_t == MAX_9) r.cs_t = '0;
      else begin r.cs_t = t.cs_t + 4'd1; carry = 1'b0; end
    end
    if (carry) begin
      if (t.sec_o == MAX_9) r.sec_o = '0;
      else begin r.sec_o = t.sec_o + 4'd1; carry = 1'b0; end
    end
    if (carry) begin
      if (t.sec_t == MAX_5) r.sec_t = '0;
      else begin r.sec_t = t.sec_t + 3'd1; carry = 1'b0; end
    end
    if (carry) begin
      if (t.min_o == MAX_9) r.min_o = '0;
      else begin r.min_o = t.min_o + 4'd1; carry = 1'b0; end
    end
    if (carry) begin
      if (t.min_t == MAX_5) r.min_t = '0;
      else r.min_t = t.min_t + 3'd1;
    end
    return r;
  endfunction

  // Edge detect: the _q flops preset to 1 so a button held through reset is not an event
  assign evt_ss  = bus.btn_start_stop & ~ss_q;
  assign evt_lap = bus.btn_lap        & ~lap_q;
  assign evt_clr = bus.btn_clear      & ~clr_q;

  assign presc_en = (state == RUNNING) || (state == LAP);

  tick_prescaler #(.DIV(DIV), .CNT_W(CNT_W)) u_presc (
    .clk_in (clk_in),
    .res    (res),
    .en     (presc_en),
    .clr    (presc_clr),
    .tick   (tick)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = tick ? bcd_inc(cnt) : cnt;
    snap_nxt  = snap;
    ovf_nxt   = ovf | (tick && (cnt == TIME_MAX));
    presc_clr = 1'b0;
    // Events a state ignores do not block lower-priority ones it handles
    case (state)
      IDLE: begin
        if (evt_ss) begin
          state_nxt = RUNNING;
          presc_clr = 1'b1;
        end
      end
      RUNNING: begin
        if (evt_ss) begin
          state_nxt = PAUSED;
        end else if (evt_lap) begin
          state_nxt = LAP;
          snap_nxt  = cnt;
        end
      end
      LAP: begin
        if (evt_ss)       state_nxt = PAUSED;
        else if (evt_lap) state_nxt = RUNNING;
      end
      PAUSED: begin
        if (evt_clr) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          ovf_nxt   = 1'b0;
          presc_clr = 1'b1;
        end else if (evt_ss) begin
          state_nxt = RUNNING;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (res) begin
      state <= IDLE;
      ss_q  <= 1'b1;
      lap_q <= 1'b1;
      clr_q <= 1'b1;
      cnt   <= '0;
      snap  <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      ss_q  <= bus.btn_start_stop;
      lap_q <= bus.btn_lap;
      clr_q <= bus.btn_clear;
      cnt   <= cnt_nxt;
      snap  <= snap_nxt;
      ovf   <= ovf_nxt;
    end
  end

  assign disp = (state == LAP) ? snap : cnt;

  assign bus.disp_min_t = disp.min_t;
  assign bus.disp_min_o = disp.min_o;
  assign bus.disp_sec_t = disp.sec_t;
  assign bus.disp_sec_o = disp.sec_o;
  assign bus.disp_cs_t  = disp.cs_t;
  assign bus.disp_cs_o  = disp.cs_o;
  assign bus.running    = presc_en;
  assign bus.lap_active = (state == LAP);
  assign bus.overflow   = ovf;
  assign bus.tick       = tick;

endmodule
